// File: rtl/enc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enc_pkg : shared decode constants, channel sizing and event type for the
//           encoder scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
package enc_pkg;

  localparam int MAX_NCH = 4;
  localparam int CH_W    = 2;

  // Decode key is {old_a, new_a, old_b, new_b}; only one edge per detent counts.
  localparam logic [3:0] KEY_INC_0 = 4'b0100;
  localparam logic [3:0] KEY_INC_1 = 4'b1011;
  localparam logic [3:0] KEY_DEC_0 = 4'b0001;
  localparam logic [3:0] KEY_DEC_1 = 4'b1110;
  localparam logic [3:0] KEY_ERR_0 = 4'b0101;
  localparam logic [3:0] KEY_ERR_1 = 4'b0110;
  localparam logic [3:0] KEY_ERR_2 = 4'b1001;
  localparam logic [3:0] KEY_ERR_3 = 4'b1010;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_INC  = 2'd1,
    EV_DEC  = 2'd2,
    EV_ERR  = 2'd3
  } enc_ev_t;

  function automatic enc_ev_t decode_key(input logic [3:0] key);
    enc_ev_t ev;
    ev = EV_NONE;
    case (key)
      KEY_INC_0, KEY_INC_1:                       ev = EV_INC;
      KEY_DEC_0, KEY_DEC_1:                       ev = EV_DEC;
      KEY_ERR_0, KEY_ERR_1, KEY_ERR_2, KEY_ERR_3: ev = EV_ERR;
      default:                                    ev = EV_NONE;
    endcase
    return ev;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enc_rr_arbiter : round-robin arbiter, one grant per cycle, search starts
//                  one past the last granted index.
// Rev 1.0
// ---------------------------------------------------------------------------
module enc_rr_arbiter #(
  parameter int NCH   = 3,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  output logic [NCH-1:0]   gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] last_q, last_d;
  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = 32'(last_q) + 32'(k) + 32'd1;
      if (cand >= 32'(NCH)) cand = cand - 32'(NCH);
      cand_idx = IDX_W'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid     = 1'b1;
        gnt_idx       = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
    last_d = gnt_valid ? gnt_idx : last_q;
  end

  // Last grant starts at the top index so channel 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IDX_W'(NCH - 1);
    else     last_q <= last_d;
  end

endmodule
`default_nettype wire

// File: rtl/encoder_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// encoder_scheduler : NCH quadrature encoders decoded per channel, pending
//                     events serviced round-robin by one shared adder/saturator.
// Rev 1.0
// ---------------------------------------------------------------------------
module encoder_scheduler
  import enc_pkg::*;
#(
  parameter int NCH = 3,
  parameter int VW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    enc_a,
  input  logic [NCH-1:0]    enc_b,
  input  logic              sample_tick,
  input  logic              cfg_we,
  input  logic              cfg_clr,
  input  logic [1:0]        cfg_ch,
  input  logic [3:0]        cfg_step,
  input  logic              cfg_sat,
  output logic [NCH*VW-1:0] values,
  output logic              upd_valid,
  output logic [1:0]        upd_ch,
  output logic [NCH-1:0]    err_flags
);

  localparam int DW = VW + 1;

  logic [NCH-1:0]          pend_vec, dir_vec, sat_vec, gnt_oh;
  logic [NCH-1:0][VW-1:0]  val_vec;
  logic [NCH-1:0][3:0]     step_vec;
  logic [CH_W-1:0]         gnt_idx;
  logic                    gnt_valid;

  logic                    stg_valid_q, stg_valid_d, stg_dec_q, stg_dec_d;
  logic [CH_W-1:0]         stg_ch_q, stg_ch_d;
  logic                    upd_valid_q, upd_valid_d;
  logic [CH_W-1:0]         upd_ch_q, upd_ch_d;
  logic [VW-1:0]           cur_val, new_val;
  logic [3:0]              step_eff;
  logic [DW-1:0]           step_ext, sum, diff;
  logic                    clr_on_gnt, clr_on_stg;

  enc_rr_arbiter #(.NCH(NCH), .IDX_W(CH_W)) u_arb (
    .clk       (clk),
    .rst       (reset),
    .req       (pend_vec),
    .gnt       (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Shared datapath: operates on the channel granted in the previous cycle.
  always_comb begin
    cur_val  = val_vec[stg_ch_q];
    step_eff = (step_vec[stg_ch_q] == 4'd0) ? 4'd1 : step_vec[stg_ch_q];
    step_ext = DW'(step_eff);
    sum      = {1'b0, cur_val} + step_ext;
    diff     = {1'b0, cur_val} - step_ext;
    new_val  = stg_dec_q ? diff[VW-1:0] : sum[VW-1:0];
    if (sat_vec[stg_ch_q]) begin
      if (!stg_dec_q && sum[VW]) new_val = '1;
      if (stg_dec_q && diff[VW]) new_val = '0;
    end
  end

  always_comb begin
    clr_on_gnt  = cfg_clr && (cfg_ch == gnt_idx);
    clr_on_stg  = cfg_clr && (cfg_ch == stg_ch_q);
    stg_valid_d = gnt_valid && !clr_on_gnt;
    stg_ch_d    = gnt_valid ? gnt_idx : stg_ch_q;
    stg_dec_d   = gnt_valid ? dir_vec[gnt_idx] : stg_dec_q;
    upd_valid_d = stg_valid_q && !clr_on_stg;
    upd_ch_d    = upd_valid_d ? stg_ch_q : upd_ch_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_valid_q <= 1'b0;
      stg_ch_q    <= '0;
      stg_dec_q   <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_ch_q    <= stg_ch_d;
      stg_dec_q   <= stg_dec_d;
      upd_valid_q <= upd_valid_d;
      upd_ch_q    <= upd_ch_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]    sync_a_q, sync_a_d, sync_b_q, sync_b_d;
    logic          smp_a_q, smp_a_d, smp_b_q, smp_b_d;
    logic          pend_q, pend_d, dir_q, dir_d, err_q, err_d, sat_q, sat_d;
    logic [3:0]    step_q, step_d;
    logic [VW-1:0] val_q, val_d;
    logic          sel, is_move, is_dec;
    enc_ev_t       ev;

    always_comb begin
      sel      = (cfg_ch == CH_W'(i));
      sync_a_d = {sync_a_q[0], enc_a[i]};
      sync_b_d = {sync_b_q[0], enc_b[i]};
      smp_a_d  = sample_tick ? sync_a_q[1] : smp_a_q;
      smp_b_d  = sample_tick ? sync_b_q[1] : smp_b_q;
      ev       = sample_tick ? decode_key({smp_a_q, sync_a_q[1], smp_b_q, sync_b_q[1]})
                             : EV_NONE;
      is_move  = (ev == EV_INC) || (ev == EV_DEC);
      is_dec   = (ev == EV_DEC);

      pend_d = pend_q && !gnt_oh[i];
      dir_d  = dir_q;
      err_d  = err_q;
      step_d = step_q;
      sat_d  = sat_q;
      val_d  = val_q;

      if (cfg_we && sel) begin
        step_d = cfg_step;
        sat_d  = cfg_sat;
        err_d  = 1'b0;
      end
      // A slot being granted this cycle is free to take the new event.
      if (is_move) begin
        if (!pend_q || gnt_oh[i]) begin
          pend_d = 1'b1;
          dir_d  = is_dec;
        end else if (dir_q != is_dec) begin
          pend_d = 1'b0;
        end else begin
          err_d  = 1'b1;
        end
      end
      if (ev == EV_ERR) err_d = 1'b1;

      if (stg_valid_q && (stg_ch_q == CH_W'(i))) val_d = new_val;
      if (cfg_clr && sel) begin
        val_d  = '0;
        pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_a_q <= '0;
        sync_b_q <= '0;
        smp_a_q  <= 1'b0;
        smp_b_q  <= 1'b0;
        pend_q   <= 1'b0;
        dir_q    <= 1'b0;
        err_q    <= 1'b0;
        sat_q    <= 1'b0;
        step_q   <= 4'd1;
        val_q    <= '0;
      end else begin
        sync_a_q <= sync_a_d;
        sync_b_q <= sync_b_d;
        smp_a_q  <= smp_a_d;
        smp_b_q  <= smp_b_d;
        pend_q   <= pend_d;
        dir_q    <= dir_d;
        err_q    <= err_d;
        sat_q    <= sat_d;
        step_q   <= step_d;
        val_q    <= val_d;
      end
    end

    assign pend_vec[i]  = pend_q;
    assign dir_vec[i]   = dir_q;
    assign sat_vec[i]   = sat_q;
    assign step_vec[i]  = step_q;
    assign val_vec[i]   = val_q;
    assign err_flags[i] = err_q;
  end

  assign values    = val_vec;
  assign upd_valid = upd_valid_q;
  assign upd_ch    = upd_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_encoder_scheduler : directed stimulus with a scoreboard queue of
//                        expected (channel, value) updates.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_encoder_scheduler;

  localparam int NCH = 3;
  localparam int VW  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH-1:0]    enc_a = '0;
  logic [NCH-1:0]    enc_b = '0;
  logic              sample_tick = 1'b0;
  logic              cfg_we = 1'b0;
  logic              cfg_clr = 1'b0;
  logic [1:0]        cfg_ch = '0;
  logic [3:0]        cfg_step = '0;
  logic              cfg_sat = 1'b0;
  logic [NCH*VW-1:0] values;
  logic              upd_valid;
  logic [1:0]        upd_ch;
  logic [NCH-1:0]    err_flags;

  always #5 clk = ~clk;

  encoder_scheduler #(.NCH(NCH), .VW(VW)) dut (
    .clk         (clk),
    .reset       (reset),
    .enc_a       (enc_a),
    .enc_b       (enc_b),
    .sample_tick (sample_tick),
    .cfg_we      (cfg_we),
    .cfg_clr     (cfg_clr),
    .cfg_ch      (cfg_ch),
    .cfg_step    (cfg_step),
    .cfg_sat     (cfg_sat),
    .values      (values),
    .upd_valid   (upd_valid),
    .upd_ch      (upd_ch),
    .err_flags   (err_flags)
  );

  typedef struct {
    int ch;
    int val;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   pos[NCH];

  function automatic int val_of(input int c);
    return int'(values[c*VW +: VW]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every update pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && upd_valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL upd_unexpected: ch %0d value %0d, expected no update",
                 upd_ch, val_of(int'(upd_ch)));
      end else begin
        e = q.pop_front();
        if (int'(upd_ch) != e.ch || val_of(e.ch) != e.val) begin
          fails++;
          $display("FAIL upd: ch %0d value %0d, expected ch %0d value %0d",
                   upd_ch, val_of(int'(upd_ch)), e.ch, e.val);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Gray positions: 0=00, 1=10, 2=11, 3=01 as {A,B}.
  task automatic apply_pins();
    for (int c = 0; c < NCH; c++) begin
      enc_a[c] = (pos[c] == 1) || (pos[c] == 2);
      enc_b[c] = (pos[c] >= 2);
    end
  endtask

  task automatic mv(input int c, input int d);
    pos[c] = (pos[c] + d + 4) % 4;
    apply_pins();
  endtask

  task automatic tick();
    repeat (3) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  // Moves odd positions to even without producing an event.
  task automatic align(input logic [NCH-1:0] mask, input int d);
    bit any;
    any = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (mask[c] && (pos[c] % 2 == 1)) begin
        mv(c, d);
        any = 1'b1;
      end
    if (any) tick();
  endtask

  task automatic detent(input logic [NCH-1:0] mask, input int d);
    align(mask, d);
    for (int c = 0; c < NCH; c++)
      if (mask[c]) mv(c, d);
    tick();
  endtask

  task automatic expect_upd(input int c, input int v);
    exp_t x;
    x.ch  = c;
    x.val = v;
    q.push_back(x);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d updates outstanding, expected 0", name, q.size());
      q.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic cfg_write(input int c, input int step, input bit sat);
    @(negedge clk);
    cfg_ch   = 2'(c);
    cfg_step = 4'(step);
    cfg_sat  = sat;
    cfg_we   = 1'b1;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_clear(input int c);
    @(negedge clk);
    cfg_ch  = 2'(c);
    cfg_clr = 1'b1;
    @(negedge clk);
    cfg_clr = 1'b0;
  endtask

  task automatic burst(input int d2_second, input int d2_third);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    mv(0, 1);
    mv(1, 1);
    mv(2, 1);
    @(negedge clk);
    mv(2, d2_second);
    @(negedge clk);
    mv(2, d2_third);
    repeat (6) @(negedge clk);
    sample_tick = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) pos[c] = 0;
    repeat (2) @(negedge clk);
    chk("rst_values", int'(values), 0);
    chk("rst_err", int'(err_flags), 0);
    chk("rst_upd_valid", int'(upd_valid), 0);
    chk("rst_upd_ch", int'(upd_ch), 0);
    reset = 1'b0;
    tick();

    // ch0: 00 -> 10 -> 11 gives exactly one increment
    expect_upd(0, 1);
    detent(3'b001, 1);
    mv(0, 1);
    tick();
    drain("ch0_first_inc");
    chk("ch0_after_inc", val_of(0), 1);

    cfg_clear(3);
    repeat (3) @(negedge clk);
    chk("clr_ch3_ignored", val_of(0), 1);

    // ch2 alone so the next search starts at ch0
    expect_upd(2, 1);
    detent(3'b100, 1);
    drain("ch2_solo");

    expect_upd(0, 2);
    expect_upd(1, 1);
    expect_upd(2, 2);
    detent(3'b111, 1);
    drain("rr_round1");
    expect_upd(0, 3);
    expect_upd(1, 2);
    expect_upd(2, 3);
    detent(3'b111, 1);
    drain("rr_round2");

    // ch1 step/saturate/wrap
    cfg_write(1, 4, 1'b0);
    cfg_clear(1);
    repeat (3) @(negedge clk);
    chk("ch1_cleared", val_of(1), 0);
    expect_upd(1, 252);
    detent(3'b010, -1);
    drain("ch1_wrap_dec");
    cfg_write(1, 5, 1'b1);
    expect_upd(1, 255);
    detent(3'b010, 1);
    drain("ch1_sat_high");
    expect_upd(1, 250);
    detent(3'b010, -1);
    drain("ch1_sat_dec");
    cfg_write(1, 2, 1'b0);
    expect_upd(1, 252);
    detent(3'b010, 1);
    drain("ch1_step2");
    cfg_write(1, 5, 1'b0);
    expect_upd(1, 1);
    detent(3'b010, 1);
    drain("ch1_wrap_inc");
    cfg_write(1, 5, 1'b1);
    expect_upd(1, 0);
    detent(3'b010, -1);
    drain("ch1_sat_low");
    cfg_write(1, 0, 1'b0);
    expect_upd(1, 1);
    detent(3'b010, 1);
    drain("ch1_step0");

    // ch2 both pins toggle together
    pos[2] = (pos[2] + 2) % 4;
    apply_pins();
    tick();
    drain("ch2_err_quiet");
    chk("ch2_err_set", int'(err_flags), 3'b100);
    chk("ch2_err_value", val_of(2), 3);
    cfg_write(2, 1, 1'b0);
    @(negedge clk);
    chk("ch2_err_cleared", int'(err_flags), 0);

    // busy arbiter: same-direction event on a full ch2 slot is dropped
    expect_upd(2, 4);
    detent(3'b100, 1);
    drain("ch2_ptr_setup");
    align(3'b111, 1);
    expect_upd(0, 4);
    expect_upd(1, 2);
    expect_upd(2, 5);
    burst(1, 1);
    drain("burst_same_dir");
    chk("burst_same_err", int'(err_flags), 3'b100);
    chk("burst_same_val2", val_of(2), 5);
    cfg_write(3, 7, 1'b1);
    @(negedge clk);
    chk("cfg_ch3_ignored", int'(err_flags), 3'b100);

    // opposite-direction event cancels the pending ch2 slot
    align(3'b111, 1);
    expect_upd(0, 5);
    expect_upd(1, 3);
    burst(-1, -1);
    drain("burst_cancel");
    chk("cancel_val2", val_of(2), 5);
    chk("cancel_err", int'(err_flags), 3'b100);

    // async reset while an update is in flight
    align(3'b001, 1);
    mv(0, 1);
    tick();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_values", int'(values), 0);
    chk("async_rst_err", int'(err_flags), 0);
    chk("async_rst_upd", int'(upd_valid), 0);
    for (int c = 0; c < NCH; c++) pos[c] = 0;
    apply_pins();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drain("post_reset_idle");
    expect_upd(0, 1);
    expect_upd(2, 1);
    detent(3'b101, 1);
    drain("post_reset_order");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
